gpio_pad_bank: RTL and testbench

- Parametrised multi-channel controller that drives a bank of bidirectional pad cells (DIN/OEN/DOUT interface, OEN active-low) from a single clock domain.
- Registers the output path and supports push-pull or open-drain per channel.
- Synchronises and optionally deglitches pad inputs.
- Records sticky rise/fall events with a maskable interrupt.
- Sits between the GPIO register block and the pad ring.

---
 rtl/gpio_pad_bank.sv | 156 +++++++++++++++
 tb/tb_gpio_pad_bank.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_bank.sv
// gpio_pad_bank
//   Multi-channel GPIO pad controller sitting between the GPIO register block
//   and the pad ring. Drives bidirectional pad cells (DIN/OEN/DOUT, OEN
//   active-low), supports push-pull or open-drain output per channel,
//   synchronises and optionally deglitches pad inputs, and records sticky
//   rise/fall events with a maskable interrupt.
//
// Ports
//   clk           system clock
//   resetn        asynchronous active-low reset
//   out_value     requested output level per channel
//   out_enable    1 = channel drives the pad
//   open_drain    1 = open-drain mode, 0 = push-pull
//   filter_enable 1 = glitch filter active on channel
//   filter_limit  stable-cycle count required by the filter (all channels)
//   pad_din       to pad cell DIN
//   pad_oen       to pad cell OEN, 0 = driving
//   pad_dout      from pad cell DOUT, asynchronous to clk
//   in_value      synchronised, filtered input level
//   rise_pending  sticky rising-edge flags
//   fall_pending  sticky falling-edge flags
//   rise_mask     1 = rise_pending contributes to irq
//   fall_mask     1 = fall_pending contributes to irq
//   clear_rise    1-cycle pulse clears the rise_pending bit
//   clear_fall    1-cycle pulse clears the fall_pending bit
//   irq           OR of masked pending flags

module gpio_pad_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,   // must be at least 2
    parameter int FILTER_BITS = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [WIDTH-1:0]       out_value,
    input  logic [WIDTH-1:0]       out_enable,
    input  logic [WIDTH-1:0]       open_drain,
    input  logic [WIDTH-1:0]       filter_enable,
    input  logic [FILTER_BITS-1:0] filter_limit,
    output logic [WIDTH-1:0]       pad_din,
    output logic [WIDTH-1:0]       pad_oen,
    input  logic [WIDTH-1:0]       pad_dout,
    output logic [WIDTH-1:0]       in_value,
    output logic [WIDTH-1:0]       rise_pending,
    output logic [WIDTH-1:0]       fall_pending,
    input  logic [WIDTH-1:0]       rise_mask,
    input  logic [WIDTH-1:0]       fall_mask,
    input  logic [WIDTH-1:0]       clear_rise,
    input  logic [WIDTH-1:0]       clear_fall,
    output logic                   irq
);

    // ------------------------------------------------------------------
    // Output path: one register stage in front of the pad cell.
    // An open-drain channel never drives DIN high; it only enables the
    // driver (OEN=0) when asked to output a 0, otherwise it floats.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] din_next;
    logic [WIDTH-1:0] oen_next;

    assign din_next = out_value & ~open_drain;
    assign oen_next = (~open_drain & ~out_enable)
                    | ( open_drain & ~(out_enable & ~out_value));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pad_din <= '0;
            pad_oen <= '1;              // all channels tristate
        end else begin
            pad_din <= din_next;
            pad_oen <= oen_next;
        end
    end

    // ------------------------------------------------------------------
    // Input synchroniser: SYNC_STAGES flops per channel.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;

    // NOTE: this array is a chain of ordinary flops, not a RAM, so it is
    // reset like any other register and cannot carry stale pad history
    // out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pad_dout;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Glitch filter. A channel's counter runs only while the synchronised
    // level disagrees with in_value; any agreement restarts it. The >=
    // compare lets a lowered filter_limit take effect at once, and the
    // counter is cleared on acceptance so it never wraps. With the filter
    // disabled (or limit 0) a disagreement is accepted immediately.
    // ------------------------------------------------------------------
    logic [FILTER_BITS-1:0] cnt_q [WIDTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_value <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == in_value[i]) begin
                    cnt_q[i] <= '0;
                end else if (!filter_enable[i] || (cnt_q[i] >= filter_limit)) begin
                    in_value[i] <= sync[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge detect and sticky pending flags. A new event overrides a clear
    // arriving in the same cycle so no edge is ever lost.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] in_prev_q;
    logic [WIDTH-1:0] rise_event;
    logic [WIDTH-1:0] fall_event;

    assign rise_event =  in_value & ~in_prev_q;
    assign fall_event = ~in_value &  in_prev_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_prev_q    <= '0;
            rise_pending <= '0;
            fall_pending <= '0;
        end else begin
            in_prev_q    <= in_value;
            rise_pending <= (rise_pending & ~clear_rise) | rise_event;
            fall_pending <= (fall_pending & ~clear_fall) | fall_event;
        end
    end

    // Combinational from registers so mask writes reach irq in the same cycle.
    assign irq = |((rise_pending & rise_mask) | (fall_pending & fall_mask));

endmodule

// File: tb/tb_gpio_pad_bank.sv
// tb_gpio_pad_bank
//   Directed bench for gpio_pad_bank (WIDTH=8, SYNC_STAGES=2, FILTER_BITS=4).
//   Stimulus pushes hand-computed expectations, tagged with the cycle they
//   apply to, into a scoreboard queue; a monitor on the falling clock edge
//   pops every entry due in that cycle and compares it with the DUT.

module tb_gpio_pad_bank;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FILTER_BITS = 4;

    typedef enum {S_DIN, S_OEN, S_IN, S_RISE, S_FALL, S_IRQ} sig_e;

    typedef struct {
        int         cyc;
        sig_e       sig;
        logic [7:0] val;
        logic [7:0] mask;
    } exp_t;

    logic                   clk;
    logic                   resetn;
    logic [WIDTH-1:0]       out_value;
    logic [WIDTH-1:0]       out_enable;
    logic [WIDTH-1:0]       open_drain;
    logic [WIDTH-1:0]       filter_enable;
    logic [FILTER_BITS-1:0] filter_limit;
    logic [WIDTH-1:0]       pad_din;
    logic [WIDTH-1:0]       pad_oen;
    logic [WIDTH-1:0]       pad_dout;
    logic [WIDTH-1:0]       in_value;
    logic [WIDTH-1:0]       rise_pending;
    logic [WIDTH-1:0]       fall_pending;
    logic [WIDTH-1:0]       rise_mask;
    logic [WIDTH-1:0]       fall_mask;
    logic [WIDTH-1:0]       clear_rise;
    logic [WIDTH-1:0]       clear_fall;
    logic                   irq;

    int   cyc;
    int   tests_run;
    int   fails;
    exp_t exp_q[$];

    gpio_pad_bank #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_BITS (FILTER_BITS)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .out_value     (out_value),
        .out_enable    (out_enable),
        .open_drain    (open_drain),
        .filter_enable (filter_enable),
        .filter_limit  (filter_limit),
        .pad_din       (pad_din),
        .pad_oen       (pad_oen),
        .pad_dout      (pad_dout),
        .in_value      (in_value),
        .rise_pending  (rise_pending),
        .fall_pending  (fall_pending),
        .rise_mask     (rise_mask),
        .fall_mask     (fall_mask),
        .clear_rise    (clear_rise),
        .clear_fall    (clear_fall),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sample(input sig_e s);
        case (s)
            S_DIN:   return pad_din;
            S_OEN:   return pad_oen;
            S_IN:    return in_value;
            S_RISE:  return rise_pending;
            S_FALL:  return fall_pending;
            default: return {7'd0, irq};
        endcase
    endfunction

    function automatic string sig_name(input sig_e s);
        case (s)
            S_DIN:   return "pad_din";
            S_OEN:   return "pad_oen";
            S_IN:    return "in_value";
            S_RISE:  return "rise_pending";
            S_FALL:  return "fall_pending";
            default: return "irq";
        endcase
    endfunction

    // Scoreboard monitor: compares every expectation due in this cycle.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                logic [7:0] act;
                act = sample(exp_q[i].sig);
                tests_run++;
                if (((act ^ exp_q[i].val) & exp_q[i].mask) !== 8'h00) begin
                    fails++;
                    $display("FAIL %s @cycle %0d: got %02h, want %02h (mask %02h)",
                             sig_name(exp_q[i].sig), cyc, act, exp_q[i].val, exp_q[i].mask);
                end
                exp_q.delete(i);
            end else if (exp_q[i].cyc < cyc) begin
                tests_run++;
                fails++;
                $display("FAIL %s: expectation for cycle %0d never sampled",
                         sig_name(exp_q[i].sig), exp_q[i].cyc);
                exp_q.delete(i);
            end
        end
    end

    // Advance n cycles; inputs change 1 ns after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expect signal s to equal v (under mask m) 'off' cycles from now.
    task automatic expect_at(input int off, input sig_e s,
                             input logic [7:0] v, input logic [7:0] m);
        exp_t e;
        e.cyc  = cyc + off;
        e.sig  = s;
        e.val  = v;
        e.mask = m;
        exp_q.push_back(e);
    endtask

    initial begin
        cyc       = 0;
        tests_run = 0;
        fails     = 0;

        // ---------------- Reset with random inputs ----------------
        resetn        = 1'b0;
        out_value     = 8'($urandom);
        out_enable    = 8'($urandom);
        open_drain    = 8'($urandom);
        filter_enable = 8'($urandom);
        filter_limit  = 4'($urandom);
        pad_dout      = 8'($urandom);
        rise_mask     = 8'($urandom);
        fall_mask     = 8'($urandom);
        clear_rise    = 8'($urandom);
        clear_fall    = 8'($urandom);
        tick(2);
        expect_at(0, S_OEN,  8'hFF, 8'hFF);
        expect_at(0, S_DIN,  8'h00, 8'hFF);
        expect_at(0, S_IN,   8'h00, 8'hFF);
        expect_at(0, S_RISE, 8'h00, 8'hFF);
        expect_at(0, S_FALL, 8'h00, 8'hFF);
        expect_at(0, S_IRQ,  8'h00, 8'h01);
        tick(1);

        // ---------------- Release, push-pull output ----------------
        out_value     = 8'h05;
        out_enable    = 8'h0F;
        open_drain    = 8'h00;
        filter_enable = 8'h00;
        filter_limit  = 4'd0;
        pad_dout      = 8'h00;
        rise_mask     = 8'h00;
        fall_mask     = 8'h00;
        clear_rise    = 8'h00;
        clear_fall    = 8'h00;
        resetn        = 1'b1;
        expect_at(0, S_OEN, 8'hFF, 8'hFF);
        expect_at(1, S_OEN, 8'hF0, 8'hFF);
        expect_at(1, S_DIN, 8'h05, 8'hFF);
        tick(2);

        // ---------------- Open-drain on channel 3 ----------------
        open_drain = 8'h08;
        out_value  = 8'h0D;                     // ch3 = 1 -> released
        expect_at(1, S_OEN, 8'hF8, 8'hFF);
        expect_at(1, S_DIN, 8'h05, 8'hFF);
        tick(2);
        out_value  = 8'h05;                     // ch3 = 0 -> drive low
        expect_at(1, S_OEN, 8'hF0, 8'hFF);
        expect_at(1, S_DIN, 8'h05, 8'hFF);
        tick(2);
        out_enable = 8'h07;                     // ch3 disabled -> released
        expect_at(1, S_OEN, 8'hF8, 8'hFF);
        tick(2);

        // ---------------- Unfiltered latency on channel 0 ----------------
        rise_mask = 8'h01;
        pad_dout  = 8'h01;
        expect_at(2, S_IN,   8'h00, 8'h01);
        expect_at(3, S_IN,   8'h01, 8'h01);
        expect_at(3, S_RISE, 8'h00, 8'h01);
        expect_at(4, S_RISE, 8'h01, 8'h01);
        expect_at(3, S_IRQ,  8'h00, 8'h01);
        expect_at(4, S_IRQ,  8'h01, 8'h01);
        tick(5);
        rise_mask = 8'h00;                      // mask reaches irq same cycle
        expect_at(0, S_IRQ, 8'h00, 8'h01);
        tick(1);
        rise_mask = 8'h01;
        expect_at(0, S_IRQ, 8'h01, 8'h01);
        tick(1);
        clear_rise = 8'h01;
        expect_at(1, S_RISE, 8'h00, 8'h01);
        expect_at(1, S_IRQ,  8'h00, 8'h01);
        tick(1);
        clear_rise = 8'h00;
        tick(2);

        // ---------------- Glitch filter on channel 1, limit 4 ----------------
        filter_limit  = 4'd4;
        filter_enable = 8'h02;
        pad_dout      = 8'h03;                  // 4-cycle pulse: rejected
        for (int k = 1; k <= 10; k++) begin
            expect_at(k, S_IN, 8'h00, 8'h02);
        end
        expect_at(12, S_RISE, 8'h00, 8'h02);
        tick(4);
        pad_dout = 8'h01;
        tick(10);
        pad_dout = 8'h03;                       // sustained high
        expect_at(6, S_IN,   8'h00, 8'h02);
        expect_at(7, S_IN,   8'h02, 8'h02);
        expect_at(8, S_RISE, 8'h02, 8'hFF);
        expect_at(8, S_IRQ,  8'h00, 8'h01);     // ch1 rise is masked
        tick(10);

        // ---------------- Limit 0 with filter enabled (channel 5) ----------------
        filter_enable = 8'h22;
        filter_limit  = 4'd0;
        pad_dout      = 8'h23;
        expect_at(2, S_IN, 8'h00, 8'h20);
        expect_at(3, S_IN, 8'h20, 8'h20);
        tick(6);

        // ---------------- Clear/set collision on channel 2 ----------------
        fall_mask = 8'h04;
        pad_dout  = 8'h27;
        tick(6);
        pad_dout  = 8'h23;                      // first fall
        expect_at(4, S_FALL, 8'h04, 8'h04);
        expect_at(4, S_IRQ,  8'h01, 8'h01);
        tick(6);
        pad_dout  = 8'h27;
        tick(2);
        pad_dout  = 8'h23;                      // second fall, event at +4
        expect_at(3, S_IN,   8'h00, 8'h04);
        expect_at(3, S_FALL, 8'h04, 8'h04);
        tick(3);
        clear_fall = 8'h04;                     // clear lands with the event
        expect_at(1, S_FALL, 8'h04, 8'h04);
        expect_at(1, S_IRQ,  8'h01, 8'h01);
        tick(1);
        clear_fall = 8'h00;
        tick(1);
        clear_fall = 8'h04;                     // clear with no event
        expect_at(1, S_FALL, 8'h00, 8'h04);
        expect_at(1, S_IRQ,  8'h00, 8'h01);
        tick(1);
        clear_fall = 8'h00;
        tick(2);

        // ---------------- Reset mid-filter on channel 6, limit 8 ----------------
        filter_enable = 8'h40;
        filter_limit  = 4'd8;
        pad_dout      = 8'h63;
        tick(5);                                // counter at 3
        resetn = 1'b0;
        expect_at(0, S_IN,   8'h00, 8'hFF);
        expect_at(0, S_RISE, 8'h00, 8'hFF);
        expect_at(0, S_FALL, 8'h00, 8'hFF);
        expect_at(0, S_IRQ,  8'h00, 8'h01);
        expect_at(0, S_OEN,  8'hFF, 8'hFF);
        expect_at(0, S_DIN,  8'h00, 8'hFF);
        tick(2);
        resetn = 1'b1;
        expect_at(0,  S_OEN,  8'hFF, 8'hFF);
        expect_at(1,  S_OEN,  8'hF8, 8'hFF);
        expect_at(1,  S_DIN,  8'h05, 8'hFF);
        expect_at(2,  S_IN,   8'h00, 8'hFF);
        expect_at(3,  S_IN,   8'h23, 8'hBF);    // pads held high through reset
        expect_at(4,  S_RISE, 8'h23, 8'hFF);
        expect_at(4,  S_IRQ,  8'h01, 8'h01);
        expect_at(10, S_IN,   8'h00, 8'h40);
        expect_at(11, S_IN,   8'h40, 8'h40);
        expect_at(12, S_RISE, 8'h63, 8'hFF);
        expect_at(12, S_FALL, 8'h00, 8'hFF);
        tick(14);

        // ---------------- Drain scoreboard ----------------
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            tick(1);
        end
        if (exp_q.size() != 0) begin
            tests_run++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
